// File: rtl/dist_bit_packer.sv
// Distance-code bit packer: appends variable-length codes MSB-first and emits 32-bit words,
// with flush drain. Optional statistics counters are built when BIT_PACKER_STATS_EN is defined.
module dist_bit_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [17:0] code_in,
  input  logic [4:0]  code_len_in,
  input  logic        code_valid_in,
  output logic        code_ready_out,
  input  logic        flush_in,
  output logic [31:0] word_out,
  output logic        word_valid_out,
  input  logic        word_ready_in,
  output logic        flush_done_out,
  output logic [31:0] stat_bits_out,
  output logic [31:0] stat_codes_out,
  output logic [1:0]  state_dbg,
  output logic [6:0]  cnt_dbg
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1;
  // ready/valid are decoded from registers only and never depend on the partner's signal.
  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, DONE = 2'd2} state_t;

  state_t      state, state_n;
  logic [63:0] acc, acc_n, acc_s, app;
  logic [6:0]  cnt, cnt_n, cnt_s, shamt;
  logic [4:0]  eff_len;
  logic [17:0] code_mask, code_bits;
  logic        accept, emit;

  always_comb begin
    eff_len        = (code_len_in > 5'd18) ? 5'd18 : code_len_in;
    code_mask      = ~(18'h3ffff << eff_len);
    code_bits      = code_in & code_mask;
    code_ready_out = rst_n && (state == RUN) && (cnt <= 7'd45);
    word_valid_out = rst_n && ((cnt >= 7'd32) || ((state == FLUSH) && (cnt != 7'd0)));
    flush_done_out = rst_n && (state == DONE);
    word_out       = acc[63:32];
    accept         = code_valid_in && code_ready_out;
    emit           = word_valid_out && word_ready_in;

    // Emit shifts first so a same-cycle append lands behind the surviving bits.
    acc_s = emit ? {acc[31:0], 32'd0} : acc;
    cnt_s = emit ? ((cnt >= 7'd32) ? (cnt - 7'd32) : 7'd0) : cnt;

    // A shift of 64 (empty code into empty acc) yields zero, which is harmless.
    shamt = 7'd64 - cnt_s - {2'b00, eff_len};
    app   = {46'd0, code_bits} << shamt;
    acc_n = accept ? (acc_s | app) : acc_s;
    cnt_n = accept ? (cnt_s + {2'b00, eff_len}) : cnt_s;

    state_n = state;
    case (state)
      RUN:     if (flush_in) state_n = FLUSH;
      FLUSH:   if (cnt == 7'd0) state_n = DONE;
      DONE:    state_n = RUN;
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc   <= 64'd0;
      cnt   <= 7'd0;
      state <= RUN;
    end else begin
      acc   <= acc_n;
      cnt   <= cnt_n;
      state <= state_n;
    end
  end

  assign state_dbg = state;
  assign cnt_dbg   = cnt;

`ifdef BIT_PACKER_STATS_EN
  logic [31:0] stat_bits_q, stat_codes_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_bits_q  <= 32'd0;
      stat_codes_q <= 32'd0;
    end else if (accept) begin
      stat_bits_q  <= stat_bits_q + {27'd0, eff_len};
      stat_codes_q <= stat_codes_q + 32'd1;
    end
  end

  assign stat_bits_out  = stat_bits_q;
  assign stat_codes_out = stat_codes_q;
`else
  assign stat_bits_out  = 32'd0;
  assign stat_codes_out = 32'd0;
`endif

endmodule

// File: tb/tb_dist_bit_packer.sv
// Bench for dist_bit_packer: bit-queue reference model, table vectors, directed corner
// sequences and randomized traffic.
module tb_dist_bit_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [17:0] code_in;
  logic [4:0]  code_len_in;
  logic        code_valid_in;
  logic        code_ready_out;
  logic        flush_in;
  logic [31:0] word_out;
  logic        word_valid_out;
  logic        word_ready_in;
  logic        flush_done_out;
  logic [31:0] stat_bits_out;
  logic [31:0] stat_codes_out;
  logic [1:0]  state_dbg;
  logic [6:0]  cnt_dbg;

  always #5 clk = ~clk;

  dist_bit_packer dut (
    .clk(clk), .rst_n(rst_n),
    .code_in(code_in), .code_len_in(code_len_in), .code_valid_in(code_valid_in),
    .code_ready_out(code_ready_out), .flush_in(flush_in),
    .word_out(word_out), .word_valid_out(word_valid_out), .word_ready_in(word_ready_in),
    .flush_done_out(flush_done_out),
    .stat_bits_out(stat_bits_out), .stat_codes_out(stat_codes_out),
    .state_dbg(state_dbg), .cnt_dbg(cnt_dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the pending bit stream in order, plus the flush phase.
  localparam int M_RUN = 0, M_FLUSH = 1, M_DONE = 2;
  bit          mq[$];
  int          mstate = M_RUN;
  logic [31:0] m_bits = 0, m_codes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_word();
    logic [31:0] w = 32'd0;
    for (int i = 0; i < 32; i++)
      if (i < mq.size()) w[31-i] = mq[i];
    return w;
  endfunction

  // One clock cycle: drive at negedge, compare against the model, advance the model,
  // then return just after the rising edge.
  task automatic step(input logic rst, input logic cv, input logic [17:0] code,
                      input logic [4:0] len, input logic fl, input logic wr);
    logic ex_ready, ex_valid;
    int   size_pre, el, npop;
    @(negedge clk);
    rst_n = rst; code_valid_in = cv; code_in = code; code_len_in = len;
    flush_in = fl; word_ready_in = wr;
    #1;
    size_pre = mq.size();
    ex_ready = rst && (mstate == M_RUN) && (size_pre <= 45);
    ex_valid = rst && ((size_pre >= 32) || (mstate == M_FLUSH && size_pre > 0));
    chk("ready", code_ready_out, ex_ready);
    chk("valid", word_valid_out, ex_valid);
    if (ex_valid) chk("word", word_out, model_word());
    chk("done", flush_done_out, rst && (mstate == M_DONE));
    chk("cnt", cnt_dbg, size_pre);
    chk("state", state_dbg, mstate);
`ifdef BIT_PACKER_STATS_EN
    chk("stat_bits", stat_bits_out, m_bits);
    chk("stat_codes", stat_codes_out, m_codes);
`else
    chk("stat_bits", stat_bits_out, 0);
    chk("stat_codes", stat_codes_out, 0);
`endif
    if (!rst) begin
      mq.delete(); mstate = M_RUN; m_bits = 0; m_codes = 0;
    end else begin
      if (ex_valid && wr) begin
        npop = (size_pre < 32) ? size_pre : 32;
        repeat (npop) void'(mq.pop_front());
      end
      if (cv && ex_ready) begin
        el = (len > 18) ? 18 : int'(len);
        for (int i = el - 1; i >= 0; i--) mq.push_back(code[i]);
        m_bits += el; m_codes += 1;
      end
      case (mstate)
        M_RUN:   if (fl) mstate = M_FLUSH;
        M_FLUSH: if (size_pre == 0) mstate = M_DONE;
        default: mstate = M_RUN;
      endcase
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input logic wr);
    repeat (n) step(1'b1, 1'b0, 18'd0, 5'd0, 1'b0, wr);
  endtask

  task automatic do_reset();
    repeat (2) step(1'b0, 1'($urandom), 18'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
  endtask

  typedef struct {
    logic [17:0] code;
    logic [4:0]  len;
    logic        flush_same;
    logic        exp_valid;
    logic [31:0] exp_word;
  } vec_t;
  vec_t tbl[7];

  initial begin
    logic        seen_w, seen_d;
    logic [31:0] held;
    rst_n = 1'b0; code_in = '0; code_len_in = '0; code_valid_in = 1'b0;
    flush_in = 1'b0; word_ready_in = 1'b0;

    tbl[0] = '{18'h00011,  5'd5,  1'b0, 1'b1, 32'h8800_0000};
    tbl[1] = '{18'h00001,  5'd1,  1'b1, 1'b1, 32'h8000_0000};
    tbl[2] = '{18'h3ffff,  5'd18, 1'b0, 1'b1, 32'hffff_c000};
    tbl[3] = '{18'h3ffff,  5'd31, 1'b1, 1'b1, 32'hffff_c000};
    tbl[4] = '{18'h002a5,  5'd10, 1'b0, 1'b1, 32'ha940_0000};
    tbl[5] = '{18'h3ffff,  5'd3,  1'b1, 1'b1, 32'he000_0000};
    tbl[6] = '{18'h12345,  5'd0,  1'b0, 1'b0, 32'h0000_0000};

    // Reset with random inputs, then release.
    do_reset();
    idle(1, 1'b1);
    chk("release_ready", code_ready_out, 1);
    chk("release_cnt", cnt_dbg, 0);

    // Single code followed by flush, with zero-padded partial word.
    for (int v = 0; v < 7; v++) begin
      step(1'b1, 1'b1, tbl[v].code, tbl[v].len, tbl[v].flush_same, 1'b1);
      if (!tbl[v].flush_same) step(1'b1, 1'b0, 18'd0, 5'd0, 1'b1, 1'b1);
      seen_w = 1'b0; seen_d = 1'b0;
      for (int k = 0; k < 6; k++) begin
        if (word_valid_out) begin
          chk("tbl_word", word_out, tbl[v].exp_word);
          seen_w = 1'b1;
        end
        if (flush_done_out) seen_d = 1'b1;
        idle(1, 1'b1);
      end
      chk("tbl_seen_word", seen_w, tbl[v].exp_valid);
      chk("tbl_seen_done", seen_d, 1);
      chk("tbl_cnt_after", cnt_dbg, 0);
    end

    // 0xDEADBEEF from four bytes, then 18+18 bits with a simultaneous emit.
    do_reset();
    step(1'b1, 1'b1, 18'h000de, 5'd8, 1'b0, 1'b1);
    step(1'b1, 1'b1, 18'h000ad, 5'd8, 1'b0, 1'b1);
    step(1'b1, 1'b1, 18'h000be, 5'd8, 1'b0, 1'b1);
    step(1'b1, 1'b1, 18'h000ef, 5'd8, 1'b0, 1'b1);
    chk("deadbeef_valid", word_valid_out, 1);
    chk("deadbeef_word", word_out, 32'hdead_beef);
`ifdef BIT_PACKER_STATS_EN
    chk("deadbeef_bits", stat_bits_out, 32);
    chk("deadbeef_codes", stat_codes_out, 4);
`else
    chk("deadbeef_bits", stat_bits_out, 0);
    chk("deadbeef_codes", stat_codes_out, 0);
`endif
    step(1'b1, 1'b1, 18'h3ffff, 5'd18, 1'b0, 1'b1);
    step(1'b1, 1'b1, 18'h00000, 5'd18, 1'b0, 1'b1);
    chk("ones_word", word_out, 32'hffff_c000);
    idle(1, 1'b1);
    chk("ones_cnt", cnt_dbg, 4);
    step(1'b1, 1'b0, 18'd0, 5'd0, 1'b1, 1'b1);
    idle(4, 1'b1);

    // Backpressure with 18-bit codes: ready drops past 45 bits, word holds.
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 18'($urandom), 5'd18, 1'b0, 1'b0);
    chk("bp_ready_low", code_ready_out, 0);
    chk("bp_cnt", cnt_dbg, 54);
    held = word_out;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 18'($urandom), 5'd18, 1'b0, 1'b0);
      chk("bp_hold", word_out, held);
    end
    for (int k = 0; k < 12; k++) step(1'b1, 1'b1, 18'($urandom), 5'd18, 1'b0, 1'b1);
    step(1'b1, 1'b0, 18'd0, 5'd0, 1'b1, 1'b1);
    idle(6, 1'b1);

    // Reset during a flush drops the pulse.
    step(1'b1, 1'b1, 18'h3ffff, 5'd18, 1'b0, 1'b0);
    step(1'b1, 1'b1, 18'h3ffff, 5'd18, 1'b0, 1'b0);
    step(1'b1, 1'b1, 18'h0000f, 5'd4, 1'b1, 1'b0);
    step(1'b1, 1'b0, 18'd0, 5'd0, 1'b0, 1'b1);
    do_reset();
    for (int k = 0; k < 4; k++) begin
      chk("abort_no_done", flush_done_out, 0);
      idle(1, 1'b1);
    end

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++)
      step(($urandom_range(0, 499) != 0), 1'($urandom), 18'($urandom),
           5'($urandom_range(0, 20)), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 3) != 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dist_bit_packer.md
DIST_BIT_PACKER -- requirements
Module: dist_bit_packer

Interface
REQ-001 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low; clock clk.
REQ-003 SHALL have port code_in, input, 18 bits: variable-length code, right-aligned; only the code_len_in LSBs are significant. This is the merged Huffman+extra-bits distance code.
REQ-004 SHALL have port code_len_in, input, 5 bits: number of significant bits in code_in, 0..18.
REQ-005 SHALL have port code_valid_in, input, 1 bit: code_in/code_len_in are valid this cycle.
REQ-006 SHALL have port code_ready_out, output, 1 bit: packer accepts a code this cycle.
REQ-007 SHALL have port flush_in, input, 1 bit: single-cycle request to drain all buffered bits.
REQ-008 SHALL have port word_out, output, 32 bits: packed output word, first-appended bit at bit 31.
REQ-009 SHALL have port word_valid_out, output, 1 bit: word_out is valid.
REQ-010 SHALL have port word_ready_in, input, 1 bit: downstream accepts word_out.
REQ-011 SHALL have port flush_done_out, output, 1 bit: one-cycle pulse when the flush is complete.
REQ-012 SHALL have port stat_bits_out, output, 32 bits: total bits accepted (see Configuration).
REQ-013 SHALL have port stat_codes_out, output, 32 bits: total codes accepted (see Configuration).

Function
REQ-014 SHALL hold a 64-bit MSB-aligned accumulator acc and a 7-bit occupancy count cnt (0..63); acc bits below the occupied region SHALL always be 0.
REQ-015 SHALL use FSM states RUN, FLUSH and DONE; the reset state SHALL be RUN.
REQ-016 code_ready_out SHALL be 1 only when state==RUN, cnt<=45 and rst_n==1; this is decoded combinationally from registers.
REQ-017 A code SHALL be accepted when code_valid_in and code_ready_out are both 1; the code SHALL be appended at acc[63-cnt] downward, MSB of the code first.
REQ-018 code_len_in values above 18 SHALL be treated as 18; len 0 SHALL be accepted with no bits appended, and SHALL still count as a code.
REQ-019 word_out SHALL equal acc[63:32].
REQ-020 word_valid_out SHALL be 1 when cnt>=32, or when state==FLUSH and cnt>0.
REQ-021 On a word handshake (word_valid_out and word_ready_in both 1), acc SHALL shift left by 32 with zero-fill, and cnt SHALL become max(cnt-32, 0).
REQ-022 A simultaneous accept and emit SHALL be legal in the same cycle: shift first, then append; new cnt = cnt-32+len.
REQ-023 Latency: a code accepted in cycle N that completes a word SHALL assert word_valid_out in cycle N+1.
REQ-024 word_out and word_valid_out SHALL hold stable while word_valid_out=1 and word_ready_in=0.
REQ-025 flush_in in RUN SHALL move the FSM to FLUSH; a code accepted in the same cycle SHALL be included in the flush.
REQ-026 flush_in outside RUN SHALL be ignored.
REQ-027 In FLUSH, full words SHALL be emitted first; a final partial word (1..31 bits) SHALL be emitted zero-padded in its LSBs.
REQ-028 When cnt==0 in FLUSH, the FSM SHALL go to DONE.
REQ-029 DONE SHALL last one cycle with flush_done_out=1, then return to RUN.

Reset
REQ-030 While rst_n=0 at a clk edge: acc=0, cnt=0, state=RUN, flush_done_out=0.
REQ-031 While rst_n=0: word_valid_out=0 and code_ready_out=0.
REQ-032 Statistics counters SHALL reset to 0.
REQ-033 Reset asserted mid-flush SHALL abort the flush with no flush_done_out pulse.

Configuration
REQ-034 When macro BIT_PACKER_STATS_EN is defined, stat_bits_out SHALL add the effective len and stat_codes_out SHALL add 1 on each accept, both wrapping modulo 2^32.
REQ-035 When BIT_PACKER_STATS_EN is undefined, stat_bits_out and stat_codes_out SHALL be constant 0, and no counter logic SHALL be built.

Verification
REQ-036 Hold rst_n=0 for 2 cycles with random inputs -> word_valid_out=0 and code_ready_out=0; on release, code_ready_out=1 and cnt=0.
REQ-037 Send codes (0xDE,8), (0xAD,8), (0xBE,8), (0xEF,8) with word_ready_in=1 -> word_out=0xDEADBEEF, word_valid_out=1, one cycle after the 4th accept.
REQ-038 Send (0x3FFFF,18) then (0x0,18) -> word_out=0xFFFFC000; cnt=4 after the handshake.
REQ-039 Hold word_ready_in=0 and feed len-18 codes -> code_ready_out drops when cnt>45; word_out stays stable; no code is lost after word_ready_in=1.
REQ-040 Send (0x11,5), then flush_in -> word_out=0x88000000 emitted, then a flush_done_out pulse, then state RUN with cnt=0.
REQ-041 With BIT_PACKER_STATS_EN defined, after REQ-037 -> stat_bits_out=32 and stat_codes_out=4; without the macro, both outputs SHALL read 0.
